// File: rtl/ahb_burst_seq_gen_pkg.sv
// Shared AHB encodings, sequencer state type and burst helpers.
// Used by the burst sequencer and its next-address logic.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BUSY,
    S_ERR
  } seq_state_t;

  function automatic int unsigned burst_beats(
    logic [2:0]  hburst,
    int unsigned len
  );
    int unsigned n;
    unique case (hburst)
      HBURST_SINGLE:               n = 1;
      HBURST_INCR:                 n = len;
      HBURST_WRAP4, HBURST_INCR4:  n = 4;
      HBURST_WRAP8, HBURST_INCR8:  n = 8;
      default:                     n = 16;
    endcase
    return n;
  endfunction

  function automatic logic is_wrap(logic [2:0] hburst);
    return hburst inside {HBURST_WRAP4, HBURST_WRAP8, HBURST_WRAP16};
  endfunction

  // All-ones for incrementing bursts, so one formula serves both kinds.
  function automatic logic [31:0] wrap_mask(
    logic [2:0] hburst,
    logic [2:0] hsize
  );
    if (!is_wrap(hburst)) return '1;
    return (32'(burst_beats(hburst, 0)) << hsize) - 32'd1;
  endfunction

endpackage

// File: rtl/ahb_burst_seq_gen_if.sv
// Request handshake plus AHB address-phase bundle of one master.
// master = sequencer side, slave = traffic generator / interconnect side.
interface ahb_burst_seq_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_burst;
  logic [2:0]            req_size;
  logic [LEN_W-1:0]      req_len;
  logic                  req_write;
  logic                  req_err;
  logic                  busy_req;
  logic                  HREADY;
  logic                  HRESP;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [LEN_W-1:0]      beat_idx;
  logic                  burst_done;
  logic                  err_abort;

  modport master (
    input  req_valid, req_addr, req_burst, req_size,
    input  req_len, req_write, busy_req, HREADY, HRESP,
    output req_ready, req_err, HADDR, HTRANS, HBURST,
    output HSIZE, HWRITE, beat_idx, burst_done, err_abort
  );

  modport slave (
    output req_valid, req_addr, req_burst, req_size,
    output req_len, req_write, busy_req, HREADY, HRESP,
    input  req_ready, req_err, HADDR, HTRANS, HBURST,
    input  HSIZE, HWRITE, beat_idx, burst_done, err_abort
  );
endinterface

// File: rtl/ahb_burst_seq_gen_next_addr.sv
// Next beat address (incrementing or wrapping) and detection of an
// undefined-length INCR beat landing on a 1KB boundary.
module ahb_next_addr
  import ahb_params_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int KB_BOUNDARY = 1024
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_burst,
  input  logic [2:0]            i_size,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_cross
);
  localparam logic [ADDR_WIDTH-1:0] KB_M = ADDR_WIDTH'(KB_BOUNDARY - 1);

  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_mask;

  assign w_inc   = i_addr + (ADDR_WIDTH'(1) << i_size);
  assign w_mask  = ADDR_WIDTH'(wrap_mask(i_burst, i_size));
  assign o_addr  = (i_addr & ~w_mask) | (w_inc & w_mask);
  assign o_cross = (i_burst == HBURST_INCR) && ((w_inc & KB_M) == '0);
endmodule

// File: rtl/ahb_burst_seq_gen.sv
// AHB master burst sequencer: takes one burst request and drives the
// address phase beat by beat with stalls, BUSY insertion and ERROR abort.
module ahb_burst_seq_gen
  import ahb_params_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INCR_LEN = 16,
  parameter int KB_BOUNDARY  = 1024
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_burst_seq_gen_if.master bus
);
  localparam int LW    = $clog2(MAX_INCR_LEN) + 1;
  localparam int MAXSZ = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] KB_M = ADDR_WIDTH'(KB_BOUNDARY - 1);

  seq_state_t            r_state, w_nstate;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_trans;
  logic [2:0]            r_burst, r_size;
  logic                  r_write;
  logic [LW-1:0]         r_idx, r_last_idx;
  logic                  r_pend_nseq;
  logic                  r_done, r_abort, r_rej;

  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic                  w_nxt_cross;
  logic [ADDR_WIDTH-1:0] w_step_m, w_end;
  int unsigned           w_beats;
  logic                  w_ok, w_last, w_err, w_ready;
  logic                  w_ld, w_step, w_to_busy, w_from_busy, w_to_idle;

  ahb_next_addr #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .KB_BOUNDARY (KB_BOUNDARY)
  ) u_next (
    .i_addr  (r_addr),
    .i_burst (r_burst),
    .i_size  (r_size),
    .o_addr  (w_nxt_addr),
    .o_cross (w_nxt_cross)
  );

  // Request legality
  assign w_beats  = burst_beats(bus.req_burst, 32'(bus.req_len));
  assign w_step_m = (ADDR_WIDTH'(1) << bus.req_size) - ADDR_WIDTH'(1);
  assign w_end    = bus.req_addr
                  + (ADDR_WIDTH'(w_beats) << bus.req_size)
                  - ADDR_WIDTH'(1);
  always_comb begin
    w_ok = 1'b1;
    if (int'(bus.req_size) > MAXSZ)
      w_ok = 1'b0;
    if ((bus.req_addr & w_step_m) != '0)
      w_ok = 1'b0;
    if (bus.req_burst inside {HBURST_INCR4, HBURST_INCR8, HBURST_INCR16}
        && (((bus.req_addr ^ w_end) & ~KB_M) != '0))
      w_ok = 1'b0;
    if (bus.req_burst == HBURST_INCR
        && (bus.req_len == '0 || int'(bus.req_len) > MAX_INCR_LEN))
      w_ok = 1'b0;
  end

  assign w_last = (r_idx == r_last_idx);
  assign w_err  = (r_state inside {S_ACTIVE, S_BUSY})
                  && bus.HRESP && !bus.HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE, S_ERR:
        w_nstate = w_ld ? S_ACTIVE : S_IDLE;
      S_ACTIVE:
        if (w_err)          w_nstate = S_ERR;
        else if (w_to_busy) w_nstate = S_BUSY;
        else if (w_to_idle) w_nstate = S_IDLE;
      S_BUSY:
        if (w_err)              w_nstate = S_ERR;
        else if (!bus.busy_req) w_nstate = S_ACTIVE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = 1'b0;
    w_ld        = 1'b0;
    w_step      = 1'b0;
    w_to_busy   = 1'b0;
    w_from_busy = 1'b0;
    w_to_idle   = 1'b0;
    unique case (r_state)
      S_IDLE, S_ERR: begin
        w_ready = 1'b1;
        w_ld    = bus.req_valid && w_ok;
      end
      S_ACTIVE: begin
        w_ready = w_last && bus.HREADY;
        if (w_err) begin
          w_to_idle = 1'b1;
        end else if (bus.HREADY) begin
          if (w_last) begin
            w_ld      = bus.req_valid && w_ok;
            w_to_idle = !w_ld;
          end else if (bus.busy_req) begin
            w_to_busy = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (w_err)              w_to_idle   = 1'b1;
        else if (!bus.busy_req) w_from_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr      <= '0;
      r_trans     <= HTRANS_IDLE;
      r_burst     <= HBURST_SINGLE;
      r_size      <= HSIZE_BYTE;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_pend_nseq <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_rej       <= 1'b0;
    end else begin
      r_done  <= (r_state == S_ACTIVE) && bus.HREADY && w_last;
      r_abort <= w_err;
      r_rej   <= bus.req_valid && w_ready && !w_ok;
      if (w_ld) begin
        r_addr     <= bus.req_addr;
        r_trans    <= HTRANS_NONSEQ;
        r_burst    <= bus.req_burst;
        r_size     <= bus.req_size;
        r_write    <= bus.req_write;
        r_idx      <= '0;
        r_last_idx <= LW'(w_beats - 1);
      end else if (w_step) begin
        r_addr  <= w_nxt_addr;
        r_trans <= w_nxt_cross ? HTRANS_NONSEQ : HTRANS_SEQ;
        r_idx   <= r_idx + LW'(1);
      end else if (w_to_busy) begin
        // Address moves on now; the beat itself is issued after BUSY.
        r_addr      <= w_nxt_addr;
        r_trans     <= HTRANS_BUSY;
        r_pend_nseq <= w_nxt_cross;
      end else if (w_from_busy) begin
        r_trans <= r_pend_nseq ? HTRANS_NONSEQ : HTRANS_SEQ;
        r_idx   <= r_idx + LW'(1);
      end else if (w_to_idle) begin
        r_trans <= HTRANS_IDLE;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.req_err    = r_rej;
  assign bus.HADDR      = r_addr;
  assign bus.HTRANS     = r_trans;
  assign bus.HBURST     = r_burst;
  assign bus.HSIZE      = r_size;
  assign bus.HWRITE     = r_write;
  assign bus.beat_idx   = r_idx;
  assign bus.burst_done = r_done;
  assign bus.err_abort  = r_abort;
endmodule

// File: tb/tb_ahb_burst_seq_gen.sv
// Bench for ahb_burst_seq_gen: directed scenarios with literal
// expectations, then random traffic against a beat-list model.
module tb_ahb_burst_seq_gen;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  ahb_burst_seq_gen_if #(.ADDR_WIDTH(32), .LEN_W(5)) bus ();

  ahb_burst_seq_gen #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .MAX_INCR_LEN (16),
    .KB_BOUNDARY  (1024)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  always #5 HCLK = ~HCLK;

  typedef enum {P_IDLE, P_ACT, P_BUSY} ph_t;

  ph_t        m_ph;
  bit [31:0]  m_a[16];
  int         m_n, m_k;
  bit [2:0]   m_burst, m_size;
  bit         m_write;
  bit [1:0]   e_trans;
  bit [31:0]  e_addr;
  int         e_idx;
  bit         e_rej, e_done, e_abort;
  int         n_vec = 0;
  int         n_bad = 0;

  bit [31:0]  wa[4]  = '{32'h38, 32'h3C, 32'h30, 32'h34};
  bit [31:0]  ia[6]  = '{32'h3F8, 32'h3FC, 32'h400,
                         32'h404, 32'h408, 32'h40C};
  bit [1:0]   it[6]  = '{2, 3, 2, 3, 3, 3};
  bit         hs[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  bit [31:0]  seen[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int beats_of(bit [2:0] b, bit [4:0] l);
    case (b)
      0:       return 1;
      1:       return int'(l);
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit req_ok(bit [31:0] a, bit [2:0] b,
                                bit [2:0] s, bit [4:0] l);
    int unsigned step, n;
    if (s > 2) return 0;
    step = 1 << s;
    if (a % step != 0) return 0;
    if (b == 1) return (l >= 1 && l <= 16);
    n = beats_of(b, l);
    if (b inside {3, 5, 7} && (a / 1024) != ((a + n * step - 1) / 1024))
      return 0;
    return 1;
  endfunction

  function automatic bit exp_ready();
    return m_ph == P_IDLE
        || (m_ph == P_ACT && m_k == m_n - 1 && bus.HREADY);
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_n = 1; m_k = 0;
    m_burst = 0; m_size = 0; m_write = 0;
    e_trans = 0; e_addr = 0; e_idx = 0;
    e_rej = 0; e_done = 0; e_abort = 0;
  endtask

  task automatic present();
    e_addr  = m_a[m_k];
    e_idx   = m_k;
    e_trans = (m_k == 0 || (m_burst == 1 && m_a[m_k] % 1024 == 0))
              ? 2'b10 : 2'b11;
  endtask

  task automatic start();
    int unsigned step, w, base;
    m_burst = bus.req_burst;
    m_size  = bus.req_size;
    m_write = bus.req_write;
    m_n     = beats_of(m_burst, bus.req_len);
    step    = 1 << m_size;
    w       = m_n * step;
    base    = bus.req_addr - (bus.req_addr % w);
    for (int i = 0; i < m_n; i++) begin
      if (m_burst inside {2, 4, 6})
        m_a[i] = base + ((bus.req_addr - base + i * step) % w);
      else
        m_a[i] = bus.req_addr + i * step;
    end
    m_k  = 0;
    m_ph = P_ACT;
    present();
  endtask

  task automatic model_step();
    bit fire, ok, last;
    fire    = bus.req_valid && exp_ready();
    ok      = req_ok(bus.req_addr, bus.req_burst, bus.req_size, bus.req_len);
    last    = (m_k == m_n - 1);
    e_rej   = fire && !ok;
    e_done  = (m_ph == P_ACT) && bus.HREADY && last;
    e_abort = (m_ph != P_IDLE) && bus.HRESP && !bus.HREADY;
    if (e_abort) begin
      m_ph = P_IDLE;
      e_trans = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (fire && ok) start();
        P_ACT: if (bus.HREADY) begin
          if (last) begin
            if (fire && ok) start();
            else begin m_ph = P_IDLE; e_trans = 0; end
          end else if (bus.busy_req) begin
            m_ph = P_BUSY; e_trans = 2'b01; e_addr = m_a[m_k + 1];
          end else begin
            m_k++; present();
          end
        end
        P_BUSY: if (!bus.busy_req) begin
          m_ph = P_ACT; m_k++; present();
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("HTRANS", 32'(bus.HTRANS), 32'(e_trans));
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
    chk("req_err", 32'(bus.req_err), 32'(e_rej));
    chk("burst_done", 32'(bus.burst_done), 32'(e_done));
    chk("err_abort", 32'(bus.err_abort), 32'(e_abort));
    if (e_trans != 0) begin
      chk("HADDR", bus.HADDR, e_addr);
      chk("HBURST", 32'(bus.HBURST), 32'(m_burst));
      chk("HSIZE", 32'(bus.HSIZE), 32'(m_size));
      chk("HWRITE", 32'(bus.HWRITE), 32'(m_write));
      chk("beat_idx", 32'(bus.beat_idx), 32'(e_idx));
    end
  endtask

  task automatic cyc(bit v, bit [31:0] a, bit [2:0] b, bit [2:0] s,
                     bit [4:0] l, bit w, bit bz, bit hr, bit hp);
    @(negedge HCLK);
    bus.req_valid = v;  bus.req_addr = a;  bus.req_burst = b;
    bus.req_size  = s;  bus.req_len  = l;  bus.req_write = w;
    bus.busy_req  = bz; bus.HREADY   = hr; bus.HRESP     = hp;
    #1;
    compare_all();
    model_step();
  endtask

  task automatic idle(bit hr);
    cyc(0, 0, 0, 0, 0, 0, 0, hr, 0);
  endtask

  initial begin
    int cnt;
    bit [31:0] a;
    bit [2:0]  s;
    bit [4:0]  l;
    bit        hr;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_burst = 0;
    bus.req_size  = 0; bus.req_len  = 0; bus.req_write = 0;
    bus.busy_req  = 0; bus.HREADY   = 1; bus.HRESP     = 0;
    #3;
    chk("rst HTRANS", 32'(bus.HTRANS), 0);
    chk("rst HADDR", bus.HADDR, 0);
    chk("rst HBURST", 32'(bus.HBURST), 0);
    chk("rst HSIZE", 32'(bus.HSIZE), 0);
    chk("rst HWRITE", 32'(bus.HWRITE), 0);
    chk("rst beat_idx", 32'(bus.beat_idx), 0);
    chk("rst pulses", 32'({bus.burst_done, bus.err_abort, bus.req_err}), 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // WRAP4 word at 0x38
    cyc(1, 32'h38, 3'd2, 3'd2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("wrap4 addr", bus.HADDR, wa[i]);
      chk("wrap4 trans", 32'(bus.HTRANS), (i == 0) ? 2 : 3);
    end
    idle(1);
    chk("wrap4 done", 32'(bus.burst_done), 1);
    chk("wrap4 idle", 32'(bus.HTRANS), 0);

    // INCR8 half at 0x100 with a two-cycle stall on beat 2
    cyc(1, 32'h100, 3'd5, 3'd1, 0, 1, 0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(hs[i]);
      seen[i] = bus.HADDR;
      if (bus.HTRANS != 0) cnt++;
    end
    chk("incr8 stall0", seen[2], 32'h104);
    chk("incr8 stall1", seen[3], 32'h104);
    chk("incr8 stall2", seen[4], 32'h104);
    chk("incr8 last", seen[9], 32'h10E);
    chk("incr8 cycles", cnt, 10);
    idle(1);
    chk("incr8 done", 32'(bus.burst_done), 1);

    // INCR len 6 word across the 1KB line
    cyc(1, 32'h3F8, 3'd1, 3'd2, 5'd6, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("incr kb addr", bus.HADDR, ia[i]);
      chk("incr kb trans", 32'(bus.HTRANS), 32'(it[i]));
      chk("incr kb burst", 32'(bus.HBURST), 1);
    end
    idle(1);

    // Rejections
    cyc(1, 32'h3F8, 3'd3, 3'd2, 0, 0, 0, 1, 0);
    idle(1);
    chk("rej kb err", 32'(bus.req_err), 1);
    chk("rej kb idle", 32'(bus.HTRANS), 0);
    idle(1);
    chk("rej kb pulse", 32'(bus.req_err), 0);
    cyc(1, 32'h0, 3'd0, 3'd3, 0, 0, 0, 1, 0);
    idle(1);
    chk("rej size err", 32'(bus.req_err), 1);
    chk("rej size idle", 32'(bus.HTRANS), 0);

    // INCR16 aborted by ERROR on beat 2
    cyc(1, 32'h0, 3'd7, 3'd2, 0, 0, 0, 1, 0);
    idle(1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("err beat2", bus.HADDR, 32'h8);
    idle(1);
    chk("err idle", 32'(bus.HTRANS), 0);
    chk("err abort", 32'(bus.err_abort), 1);
    chk("err ready", 32'(bus.req_ready), 1);

    // INCR4 word with one BUSY after beat 0
    cyc(1, 32'h20, 3'd3, 3'd2, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("busy b0", bus.HADDR, 32'h20);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("busy trans", 32'(bus.HTRANS), 1);
    chk("busy addr", bus.HADDR, 32'h24);
    chk("busy idx", 32'(bus.beat_idx), 0);
    idle(1);
    chk("busy seq", 32'(bus.HTRANS), 3);
    chk("busy seq addr", bus.HADDR, 32'h24);
    idle(1);
    idle(1);
    chk("busy last", bus.HADDR, 32'h2C);
    idle(1);

    // Asynchronous reset mid-burst
    cyc(1, 32'h80, 3'd5, 3'd2, 0, 0, 0, 1, 0);
    idle(1);
    idle(1);
    chk("pre-rst addr", bus.HADDR, 32'h84);
    #1 HRESETn = 1'b0;
    #1;
    chk("async HTRANS", 32'(bus.HTRANS), 0);
    chk("async HADDR", bus.HADDR, 0);
    chk("async idx", 32'(bus.beat_idx), 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      s = ($urandom % 10 == 0) ? 3'd3 : 3'($urandom % 3);
      if ($urandom % 4 == 0)
        a = 32'h400 * $urandom_range(1, 3) - 4 * $urandom_range(0, 15);
      else
        a = $urandom_range(0, 32'hFFF);
      if ($urandom % 8 != 0) a = a & ~((32'd1 << s) - 1);
      if ($urandom % 8 == 0)
        l = ($urandom % 2) ? 5'd0 : 5'($urandom_range(17, 31));
      else
        l = 5'($urandom_range(1, 16));
      hr = ($urandom % 5 != 0);
      cyc($urandom % 3 == 0, a, 3'($urandom % 8), s, l,
          1'($urandom % 2), $urandom % 6 == 0, hr,
          !hr && ($urandom % 8 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
